// File: rtl/bubble_sort_seq_if.sv
// ----------------------------------------------------------------------------
// bubble_sort_seq_if
// Bundles the input stream, the output stream and the status signals of the
// sequential sorting engine.
//   in_valid / in_ready / in_data / descend : word input stream plus sort order
//   out_valid / out_ready / out_data / out_last : sorted word output stream
//   busy     : engine is sorting or streaming a result
//   pass_cnt : passes executed for the last/current frame
// The engine connects through the slave modport. The producer and consumer
// side connects through the master modport.
// ----------------------------------------------------------------------------
interface bubble_sort_seq_if #(
    parameter int N     = 5,
    parameter int WIDTH = 8
);
    localparam int PW = $clog2(N + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             descend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic [PW-1:0]    pass_cnt;

    // Producer/consumer side: drives the words in and the ready for words out
    modport master (
        output in_valid, in_data, descend, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, pass_cnt
    );

    // Engine side
    modport slave (
        input  in_valid, in_data, descend, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, pass_cnt
    );
endinterface

// File: rtl/bubble_sort_seq.sv
// ----------------------------------------------------------------------------
// bubble_sort_seq
// Sequential sorting engine. It collects N unsigned words from a valid/ready
// stream and sorts them with odd-even transposition passes, one pass per
// clock. It stops early once two passes in a row made no swap, then streams
// the sorted words out. The sort order (ascending/descending) is chosen per
// frame by the descend bit that comes with the first word.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; discards any frame in progress
//   bus : bubble_sort_seq_if.slave (input stream, output stream, busy, pass_cnt)
// ----------------------------------------------------------------------------
module bubble_sort_seq #(
    parameter int N     = 5,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bubble_sort_seq_if.slave     bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(N + 1);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        OUT
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_arr [N];
    logic [WIDTH-1:0] w_next [N];
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_oidx;
    logic             r_descend;
    logic [PW-1:0]    r_passCnt;
    logic             r_prevNoSwap;

    logic             w_inBeat;
    logic             w_outBeat;
    logic             w_outLast;
    logic             w_anySwap;
    logic             w_sortDone;
    logic             w_loadLast;

    // Handshake qualifiers. A word is accepted only while loading and a result
    // word only leaves while streaming, so in_valid in other states is ignored.
    assign w_inBeat   = (r_state == LOAD) && bus.in_valid;
    assign w_loadLast = (r_idx == IW'(N - 1));
    assign w_outLast  = (r_state == OUT) && (r_oidx == IW'(N - 1));
    assign w_outBeat  = (r_state == OUT) && bus.out_ready;

    // One odd-even transposition pass over the current array. Pass parity
    // comes from the pass counter: even passes compare pairs starting at 0,
    // odd passes pairs starting at 1. Pairs in one pass never overlap, so all
    // swaps can be applied at once. Equal words are never swapped.
    always_comb begin
        w_next    = r_arr;
        w_anySwap = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (k[0] == r_passCnt[0]) begin
                if (r_descend ? (r_arr[k] < r_arr[k+1]) : (r_arr[k] > r_arr[k+1])) begin
                    w_next[k]   = r_arr[k+1];
                    w_next[k+1] = r_arr[k];
                    w_anySwap   = 1'b1;
                end
            end
        end
    end

    // Sorting finishes after the current pass if it and the pass before it
    // both left the array untouched, or if this is the N-th pass, which is
    // enough for odd-even transposition to sort any input.
    assign w_sortDone = (!w_anySwap && r_prevNoSwap) || (r_passCnt == PW'(N - 1));

    // State register of the control FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: load N words, sort, stream N words, back to load.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            LOAD: begin
                if (w_inBeat && w_loadLast) begin
                    w_nextState = SORT;
                end
            end
            SORT: begin
                if (w_sortDone) begin
                    w_nextState = OUT;
                end
            end
            OUT: begin
                if (w_outBeat && w_outLast) begin
                    w_nextState = LOAD;
                end
            end
            default: begin
                w_nextState = LOAD;
            end
        endcase
    end

    // Datapath registers. Loading writes words in arrival order and latches
    // the sort order with the first word, so a descend change mid-frame has no
    // effect. Entering SORT clears the pass counter and the "previous pass was
    // clean" flag; the counter then keeps its final value through OUT and LOAD
    // so the consumer can read it after the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                r_arr[k] <= '0;
            end
            r_idx        <= '0;
            r_oidx       <= '0;
            r_descend    <= 1'b0;
            r_passCnt    <= '0;
            r_prevNoSwap <= 1'b0;
        end else begin
            unique case (r_state)
                LOAD: begin
                    if (w_inBeat) begin
                        r_arr[r_idx] <= bus.in_data;
                        if (r_idx == '0) begin
                            r_descend <= bus.descend;
                        end
                        if (w_loadLast) begin
                            r_idx        <= '0;
                            r_passCnt    <= '0;
                            r_prevNoSwap <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                SORT: begin
                    r_arr        <= w_next;
                    r_passCnt    <= r_passCnt + 1'b1;
                    r_prevNoSwap <= !w_anySwap;
                end
                OUT: begin
                    if (w_outBeat) begin
                        if (w_outLast) begin
                            r_oidx <= '0;
                        end else begin
                            r_oidx <= r_oidx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    // Outputs. out_data is forced to zero outside OUT so that it shows the
    // reset value while nothing is being streamed.
    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_data  = (r_state == OUT) ? r_arr[r_oidx] : '0;
    assign bus.out_last  = w_outLast;
    assign bus.busy      = (r_state == SORT) || (r_state == OUT);
    assign bus.pass_cnt  = r_passCnt;

endmodule

// File: tb/tb_bubble_sort_seq.sv
// ----------------------------------------------------------------------------
// tb_bubble_sort_seq
// Self-checking bench for bubble_sort_seq (N=5, WIDTH=8). Frames are driven
// through the interface, and every output word, out_last, pass count and
// latency is compared with a reference model in this file.
// ----------------------------------------------------------------------------
module tb_bubble_sort_seq;
    localparam int N  = 5;
    localparam int W  = 8;

    typedef logic [W-1:0] frame_t [N];

    logic clk = 1'b0;
    logic rst;
    int   nVectors = 0;
    int   nMiscompares = 0;

    bubble_sort_seq_if #(.N(N), .WIDTH(W)) bus ();

    bubble_sort_seq #(.N(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Single comparison point: counts each comparison and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference result: the frame sorted by plain insertion sort
    task automatic sortRef(input frame_t w, input logic d, output frame_t r);
        int a [N];
        int t;
        for (int i = 0; i < N; i++) begin
            a[i] = int'(w[i]);
        end
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (d ? (a[j] > a[j-1]) : (a[j] < a[j-1])) begin
                    t      = a[j];
                    a[j]   = a[j-1];
                    a[j-1] = t;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            r[i] = W'(a[i]);
        end
    endtask

    // Reference pass count: replays odd-even transposition on integers and
    // applies the two stopping rules (two clean passes in a row, or N passes)
    function automatic int passRef(input frame_t w, input logic d);
        int a [N];
        int p;
        int sw;
        int t;
        bit prevZero;
        bit done;
        p        = 0;
        prevZero = 0;
        done     = 0;
        for (int i = 0; i < N; i++) begin
            a[i] = int'(w[i]);
        end
        while (!done) begin
            sw = 0;
            for (int k = p % 2; k + 1 < N; k += 2) begin
                if (d ? (a[k] < a[k+1]) : (a[k] > a[k+1])) begin
                    t      = a[k];
                    a[k]   = a[k+1];
                    a[k+1] = t;
                    sw++;
                end
            end
            p++;
            if ((sw == 0 && prevZero) || p == N) begin
                done = 1;
            end
            prevZero = (sw == 0);
        end
        return p;
    endfunction

    // Drives one frame into the engine, with optional idle gaps. descend is
    // only correct on the first word; later beats carry the inverse to show
    // the order is latched with the first word. Returns #1 after the edge that
    // accepted the last word.
    task automatic applyStimulus(input frame_t words, input logic desc, input int gapPct);
        int  i;
        int  guard;
        bit  v;
        bit  acc;
        i     = 0;
        guard = 0;
        while (i < N && guard < 20 * N) begin
            v = ($urandom_range(0, 99) >= gapPct);
            bus.in_valid = v;
            bus.in_data  = v ? words[i] : W'($urandom);
            bus.descend  = (i == 0) ? desc : ~desc;
            acc = v && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        checkOutput("loadDone", i, N);
    endtask

    // Runs a full frame: load, wait for the result, drain it under the given
    // out_ready pattern (0 always ready, 1 toggling, 2 random) and check it.
    // With junk set, in_valid stays high with garbage during SORT and OUT.
    task automatic runFrame(input frame_t words, input logic desc, input int gapPct,
                            input int readyMode, input bit junk);
        frame_t expWords;
        int     expPasses;
        int     lat;
        int     k;
        int     guard;
        logic   rdy;
        logic   tog;
        sortRef(words, desc, expWords);
        expPasses = passRef(words, desc);
        applyStimulus(words, desc, gapPct);
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'($urandom);
            bus.descend  = ~desc;
        end
        checkOutput("busySort", bus.busy, 1);
        checkOutput("readyLowSort", bus.in_ready, 0);
        lat = 1;
        while (!bus.out_valid && lat < 4 * N) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, expPasses + 1);
        checkOutput("passCnt", bus.pass_cnt, expPasses);
        checkOutput("busyOut", bus.busy, 1);
        k     = 0;
        guard = 0;
        tog   = 1'b1;
        while (k < N && guard < 20 * N) begin
            case (readyMode)
                0:       rdy = 1'b1;
                1:       rdy = tog;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tog           = ~tog;
            bus.out_ready = rdy;
            checkOutput($sformatf("valid%0d", k), bus.out_valid, 1);
            checkOutput($sformatf("data%0d", k), bus.out_data, expWords[k]);
            checkOutput($sformatf("last%0d", k), bus.out_last, (k == N - 1));
            if (junk) begin
                checkOutput("readyLowOut", bus.in_ready, 0);
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                k++;
            end
            guard++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput("drainDone", k, N);
        checkOutput("validLowAfter", bus.out_valid, 0);
        checkOutput("readyHighAfter", bus.in_ready, 1);
        checkOutput("busyLowAfter", bus.busy, 0);
        checkOutput("passHold", bus.pass_cnt, expPasses);
    endtask

    // Reset-state checks shared by power-up and the mid-sort reset
    task automatic checkResetState(input string tag);
        checkOutput({tag, "InReady"}, bus.in_ready, 1);
        checkOutput({tag, "OutValid"}, bus.out_valid, 0);
        checkOutput({tag, "OutLast"}, bus.out_last, 0);
        checkOutput({tag, "OutData"}, bus.out_data, 0);
        checkOutput({tag, "Busy"}, bus.busy, 0);
        checkOutput({tag, "PassCnt"}, bus.pass_cnt, 0);
    endtask

    // Directed frames first, then a randomized sweep
    initial begin
        frame_t f;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.descend   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("rstHeld");
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkResetState("rstReleased");

        $display("[TB] ascending and descending frames");
        f = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
        runFrame(f, 1'b0, 0, 0, 1'b0);
        runFrame(f, 1'b1, 0, 0, 1'b0);

        $display("[TB] presorted frame");
        f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        runFrame(f, 1'b0, 0, 0, 1'b0);
        checkOutput("presortedPasses", bus.pass_cnt, 2);

        $display("[TB] duplicates");
        f = '{8'd4, 8'd4, 8'd0, 8'd255, 8'd4};
        runFrame(f, 1'b0, 0, 0, 1'b0);

        $display("[TB] reversed frame");
        f = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        runFrame(f, 1'b0, 0, 0, 1'b0);
        checkOutput("reversePasses", bus.pass_cnt, 5);

        $display("[TB] toggling out_ready");
        f = '{8'd200, 8'd17, 8'd99, 8'd17, 8'd3};
        runFrame(f, 1'b0, 0, 1, 1'b0);

        $display("[TB] reset during sort");
        f = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        applyStimulus(f, 1'b0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkResetState("midSortRst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("midSortRel");
        f = '{8'd2, 8'd1, 8'd2, 8'd1, 8'd0};
        runFrame(f, 1'b0, 0, 0, 1'b0);

        $display("[TB] in_valid held during sort and output");
        f = '{8'd30, 8'd10, 8'd50, 8'd40, 8'd20};
        runFrame(f, 1'b1, 0, 0, 1'b1);
        f = '{8'd7, 8'd6, 8'd8, 8'd6, 8'd9};
        runFrame(f, 1'b0, 0, 0, 1'b0);

        $display("[TB] randomized frames");
        for (int fr = 0; fr < 24; fr++) begin
            for (int i = 0; i < N; i++) begin
                f[i] = (fr % 3 == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
            end
            runFrame(f, 1'($urandom_range(0, 1)), (fr % 2 == 1) ? 30 : 0, fr % 3, (fr % 4 == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
